serial_uart_baud_generator_prog: RTL

Programmable NCO baud generator and successor to the fixed-rate UART baud generator. The tuning word is loadable at run time, with a glitch-free switch-over at a sample boundary. The oversample ratio (2^OVERSAMPLE_LOG2) and accumulator width are parameters. The block adds ENABLE, a SYNC re-phase for receiver start-bit alignment, a mid-bit tick and a sample-phase index. One instance feeds a UART TX/RX pair: TX uses BAUD_RATE_TICK; RX uses SYNC, BAUD_SAMPLE_TICK and BAUD_MID_TICK.

---
 rtl/serial_uart_baud_generator_prog_if.sv | 40 ++++
 rtl/serial_uart_baud_generator_prog.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_uart_baud_generator_prog_if.sv
// Control/status bundle for the programmable NCO baud generator.
// The master side (UART or bench) drives enable/sync/tuning; the slave is the generator.
interface serial_uart_baud_generator_prog_if #(
    parameter int unsigned ACC_WIDTH       = 16,
    parameter int unsigned OVERSAMPLE_LOG2 = 4
);
    logic                       ENABLE;
    logic                       SYNC;
    logic [ACC_WIDTH-1:0]       TUNING_WORD;
    logic                       TUNING_LOAD;
    logic [ACC_WIDTH-1:0]       TUNING_ACTIVE;
    logic                       BAUD_SAMPLE_TICK;
    logic                       BAUD_MID_TICK;
    logic                       BAUD_RATE_TICK;
    logic [OVERSAMPLE_LOG2-1:0] SAMPLE_INDEX;

    modport master (
        output ENABLE,
        output SYNC,
        output TUNING_WORD,
        output TUNING_LOAD,
        input  TUNING_ACTIVE,
        input  BAUD_SAMPLE_TICK,
        input  BAUD_MID_TICK,
        input  BAUD_RATE_TICK,
        input  SAMPLE_INDEX
    );

    modport slave (
        input  ENABLE,
        input  SYNC,
        input  TUNING_WORD,
        input  TUNING_LOAD,
        output TUNING_ACTIVE,
        output BAUD_SAMPLE_TICK,
        output BAUD_MID_TICK,
        output BAUD_RATE_TICK,
        output SAMPLE_INDEX
    );
endinterface

// File: rtl/serial_uart_baud_generator_prog.sv
// Programmable NCO baud generator: the accumulator overflow gives the oversample tick,
// a sample-phase counter derives the mid-bit and bit-boundary ticks. The tuning word is
// double-buffered and only switched at a sample boundary (or while idle/re-phasing).
module serial_uart_baud_generator_prog #(
    parameter int unsigned CLK_RATE_HZ         = 50000000,
    parameter int unsigned BAUD_RATE           = 115200,
    parameter int unsigned ACC_WIDTH           = 16,
    parameter int unsigned OVERSAMPLE_LOG2     = 4,
    parameter int unsigned DEFAULT_TUNING_WORD = 0
) (
    input  logic                              CLK,
    input  logic                              RESET,
    serial_uart_baud_generator_prog_if.slave  bus
);

    localparam int unsigned OS = 1 << OVERSAMPLE_LOG2;

    // round(BAUD_RATE * OS * 2^N / CLK_RATE_HZ) in 64-bit arithmetic
    localparam longint unsigned LP_M_CALC =
        (((longint'(BAUD_RATE) * longint'(OS)) << ACC_WIDTH) + longint'(CLK_RATE_HZ / 2))
        / longint'(CLK_RATE_HZ);

    localparam logic [ACC_WIDTH-1:0] LP_M_RESET = (DEFAULT_TUNING_WORD != 0)
        ? ACC_WIDTH'(DEFAULT_TUNING_WORD) : ACC_WIDTH'(LP_M_CALC);

    localparam logic [OVERSAMPLE_LOG2-1:0] LP_IDX_LAST = OVERSAMPLE_LOG2'(OS - 1);
    localparam logic [OVERSAMPLE_LOG2-1:0] LP_IDX_MID  = OVERSAMPLE_LOG2'(OS / 2 - 1);
    localparam logic [OVERSAMPLE_LOG2-1:0] LP_IDX_ONE  = OVERSAMPLE_LOG2'(1);

    logic [ACC_WIDTH-1:0]       r_acc;
    logic [ACC_WIDTH-1:0]       r_m_active;
    logic [ACC_WIDTH-1:0]       r_shadow;
    logic                       r_load_pending;
    logic [OVERSAMPLE_LOG2-1:0] r_idx;
    logic                       r_sample_tick;
    logic                       r_mid_tick;
    logic                       r_rate_tick;

    logic [ACC_WIDTH:0]         w_sum;
    logic                       w_carry;
    logic                       w_apply;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_m_active};
    assign w_carry = w_sum[ACC_WIDTH];
    // Switch M only where no sample period can be split: at overflow, re-phase or idle.
    assign w_apply = r_load_pending & (w_carry | bus.SYNC | ~bus.ENABLE);

    // Phase accumulator, sample index and registered ticks; SYNC outranks ENABLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_acc         <= '0;
            r_idx         <= '0;
            r_sample_tick <= 1'b0;
            r_mid_tick    <= 1'b0;
            r_rate_tick   <= 1'b0;
        end else begin
            r_sample_tick <= 1'b0;
            r_mid_tick    <= 1'b0;
            r_rate_tick   <= 1'b0;
            if (bus.SYNC) begin
                r_acc <= '0;
                r_idx <= '0;
            end else if (bus.ENABLE) begin
                r_acc         <= w_sum[ACC_WIDTH-1:0];
                r_sample_tick <= w_carry;
                r_mid_tick    <= w_carry & (r_idx == LP_IDX_MID);
                r_rate_tick   <= w_carry & (r_idx == LP_IDX_LAST);
                if (w_carry) begin
                    r_idx <= r_idx + LP_IDX_ONE;
                end
            end
        end
    end

    // Shadow/active tuning word; a load on the apply edge re-arms with the newer value.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_m_active     <= LP_M_RESET;
            r_shadow       <= LP_M_RESET;
            r_load_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_m_active     <= r_shadow;
                r_load_pending <= 1'b0;
            end
            if (bus.TUNING_LOAD) begin
                r_shadow       <= bus.TUNING_WORD;
                r_load_pending <= 1'b1;
            end
        end
    end

    assign bus.TUNING_ACTIVE    = r_m_active;
    assign bus.BAUD_SAMPLE_TICK = r_sample_tick;
    assign bus.BAUD_MID_TICK    = r_mid_tick;
    assign bus.BAUD_RATE_TICK   = r_rate_tick;
    assign bus.SAMPLE_INDEX     = r_idx;

endmodule
